dac_update_sched: RTL

DAC_UPDATE_SCHED -- requirements
Module: dac_update_sched

---
 rtl/dac_update_sched.sv | 89 ++++++++
 1 files changed

// File: rtl/dac_update_sched.sv
// dac_update_sched: periodic/software DAC reload scheduler with I2C timeout, retry/backoff and fault latch
module dac_update_sched #(
  parameter int TIMEOUT = 4096,
  parameter int BACKOFF = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] period,
  input  logic        sw_req,
  input  logic [1:0]  retry_max,
  input  logic        fault_clr,
  input  logic        i2c_done,
  input  logic        i2c_error,
  output logic        i2c_resetn,
  output logic        i2c_enable,
  output logic        busy,
  output logic        fault,
  output logic        overrun,
  output logic [15:0] update_count,
  output logic [7:0]  err_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BACKOFF + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_BACKOFF, S_FAULT} state_t;
  state_t state_q, state_d;
  logic [15:0] timer_q, timer_d, upd_q, upd_d;
  logic [7:0] err_q, err_d;
  logic [1:0] retry_q, retry_d;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bo_q, bo_d;
  logic pending_q, pending_d, overrun_q, overrun_d;
  logic tick, req, ok, fail, can_retry;
  always_comb begin
    tick = period != 16'd0 && timer_q == 16'd0;
    timer_d = period == 16'd0 ? 16'd0 : tick ? period - 16'd1 : timer_q - 16'd1;
    req = (tick || sw_req) && state_q != S_FAULT;
    ok = state_q == S_RUN && i2c_done && !i2c_error;
    fail = state_q == S_RUN && (i2c_error || (!i2c_done && to_q == TW'(TIMEOUT - 1)));
    can_retry = retry_q < retry_max;
    pending_d = state_q == S_IDLE ? pending_q && req :
                state_q == S_FAULT ? pending_q && !fault_clr : pending_q || req;
    overrun_d = overrun_q || (req && pending_q);
    to_d = state_q == S_RUN ? to_q + TW'(1) : '0;
    bo_d = state_q == S_BACKOFF ? bo_q + BW'(1) : '0;
    upd_d = upd_q + 16'(ok);
    err_d = err_q + 8'(fail && err_q != 8'hff);
    retry_d = (ok || (state_q == S_FAULT && fault_clr)) ? 2'd0 :
              (fail && can_retry) ? retry_q + 2'd1 : retry_q;
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = (pending_q || req) ? S_LOAD : S_IDLE;
      S_LOAD:    state_d = S_RUN;
      S_RUN:     state_d = ok ? S_IDLE : fail ? (can_retry ? S_BACKOFF : S_FAULT) : S_RUN;
      S_BACKOFF: state_d = bo_q == BW'(BACKOFF - 1) ? S_LOAD : S_BACKOFF;
      S_FAULT:   state_d = fault_clr ? S_IDLE : S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      upd_q     <= '0;
      err_q     <= '0;
      retry_q   <= '0;
      to_q      <= '0;
      bo_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      to_q      <= to_d;
      bo_q      <= bo_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end
  assign i2c_resetn   = resetn && state_q != S_LOAD;
  assign i2c_enable   = state_q == S_RUN;
  assign busy         = state_q == S_LOAD || state_q == S_RUN || state_q == S_BACKOFF;
  assign fault        = state_q == S_FAULT;
  assign overrun      = overrun_q;
  assign update_count = upd_q;
  assign err_count    = err_q;
endmodule
